// File: rtl/overlay_marker_writer.sv
// overlay_marker_writer: draws clipped cross-shaped markers into an SRAM frame buffer
// as byte-masked {mask,addr,data} writes. Define OVERLAY_COALESCE_EN to merge same-word horizontal pixels.
module overlay_marker_writer #(
  parameter int          WIDTH      = 800,
  parameter int          HEIGHT     = 600,
  parameter int          XW         = 10,
  parameter int          RADIUS     = 2,
  parameter logic [7:0]  MARK_VALUE = 8'hFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          event_valid,
  output logic          event_ready,
  input  logic [XW-1:0] event_x,
  input  logic [XW-1:0] event_y,
  input  logic [17:0]   base_addr,
  output logic [53:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic [15:0]   marks_done
);
  localparam int            IW       = 19;
  localparam int            CW       = XW + 1;
  localparam logic [CW-1:0] RAD      = CW'(RADIUS);
  localparam logic [CW-1:0] X_MAX    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] Y_MAX    = CW'(HEIGHT - 1);
  localparam logic [IW-1:0] ROW_STEP = IW'(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, HORIZ, VERT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] x0_reg, x0_next, y0_reg, y0_next;
  logic [CW-1:0] x_cur_reg, x_cur_next, x_hi_reg, x_hi_next;
  logic [CW-1:0] y_cur_reg, y_cur_next, y_hi_reg, y_hi_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [17:0]   base_reg, base_next;
  logic          gen_done_reg, gen_done_next;
  logic [53:0]   dout_reg, dout_next;
  logic          dout_valid_reg, dout_valid_next;
  logic [15:0]   marks_reg, marks_next;

  // Coordinates carry one spare bit so x0+R never wraps before clipping
  logic [CW-1:0] x_sum, y_sum, x_lo_c, x_hi_c, y_lo_c, y_hi_c;
  logic          out_of_range;
  always_comb begin
    x_sum        = x0_reg + RAD;
    y_sum        = y0_reg + RAD;
    x_lo_c       = (x0_reg >= RAD) ? x0_reg - RAD : '0;
    y_lo_c       = (y0_reg >= RAD) ? y0_reg - RAD : '0;
    x_hi_c       = (x_sum > X_MAX) ? X_MAX : x_sum;
    y_hi_c       = (y_sum > Y_MAX) ? Y_MAX : y_sum;
    out_of_range = (x0_reg > X_MAX) || (y0_reg > Y_MAX);
  end

  logic [1:0]    lane, span, lane_hi;
  logic [CW-1:0] rem;
  logic [3:0]    mask;
  logic          last_h;
  assign lane = idx_reg[1:0];
  assign rem  = x_hi_reg - x_cur_reg;

`ifdef OVERLAY_COALESCE_EN
  // span = extra pixels of this row that fall in the current word
  always_comb begin
    span = 2'd0;
    if (state_reg == HORIZ)
      span = (rem < CW'(2'd3 - lane)) ? rem[1:0] : 2'd3 - lane;
  end
`else
  assign span = 2'd0;
`endif

  assign lane_hi = lane + span;
  assign last_h  = (rem == CW'(span));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign mask[gi] = (2'(gi) >= lane) && (2'(gi) <= lane_hi);
    end
  endgenerate

  logic [53:0] wr_word;
  assign wr_word = {mask, base_reg + {1'b0, idx_reg[IW-1:2]}, {4{MARK_VALUE}}};

  // During HORIZ y_cur holds y_lo; the centre row is skipped since HORIZ drew it
  logic [CW-1:0] v_first, v_next_y;
  logic [IW-1:0] v_first_idx, v_step_idx;
  logic          has_vert, v_skip, last_v;
  assign v_first     = (y_cur_reg == y0_reg) ? y0_reg + CW'(1) : y_cur_reg;
  assign v_first_idx = IW'(v_first) * ROW_STEP + IW'(x0_reg);
  assign has_vert    = (y_hi_reg != y_cur_reg);
  assign v_skip      = (y_cur_reg + CW'(1) == y0_reg);
  assign v_next_y    = y_cur_reg + (v_skip ? CW'(2) : CW'(1));
  assign v_step_idx  = v_skip ? ROW_STEP + ROW_STEP : ROW_STEP;
  assign last_v      = (v_next_y > y_hi_reg);

  logic load_en, handshake;
  assign handshake = dout_valid_reg && dout_ready;
  assign load_en   = !gen_done_reg && (!dout_valid_reg || dout_ready);

  always_comb begin
    state_next      = state_reg;
    x0_next         = x0_reg;
    y0_next         = y0_reg;
    x_cur_next      = x_cur_reg;
    x_hi_next       = x_hi_reg;
    y_cur_next      = y_cur_reg;
    y_hi_next       = y_hi_reg;
    idx_next        = idx_reg;
    base_next       = base_reg;
    gen_done_next   = gen_done_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    marks_next      = marks_reg;
    case (state_reg)
      IDLE: begin
        if (event_valid && event_ready) begin
          x0_next       = {1'b0, event_x};
          y0_next       = {1'b0, event_y};
          base_next     = base_addr;
          gen_done_next = 1'b0;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        if (out_of_range) begin
          state_next = IDLE;
        end else begin
          x_cur_next = x_lo_c;
          x_hi_next  = x_hi_c;
          y_cur_next = y_lo_c;
          y_hi_next  = y_hi_c;
          idx_next   = IW'(y0_reg) * ROW_STEP + IW'(x_lo_c);
          state_next = HORIZ;
        end
      end
      HORIZ, VERT: begin
        if (handshake)
          dout_valid_next = 1'b0;
        if (gen_done_reg && handshake) begin
          state_next = IDLE;
          marks_next = marks_reg + 16'd1;
        end else if (load_en) begin
          dout_next       = wr_word;
          dout_valid_next = 1'b1;
          if (state_reg == HORIZ) begin
            if (!last_h) begin
              x_cur_next = x_cur_reg + CW'(span) + CW'(1);
              idx_next   = idx_reg + IW'(span) + IW'(1);
            end else if (has_vert) begin
              state_next = VERT;
              y_cur_next = v_first;
              idx_next   = v_first_idx;
            end else begin
              gen_done_next = 1'b1;
            end
          end else begin
            if (last_v) begin
              gen_done_next = 1'b1;
            end else begin
              y_cur_next = v_next_y;
              idx_next   = idx_reg + v_step_idx;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      x0_reg         <= '0;
      y0_reg         <= '0;
      x_cur_reg      <= '0;
      x_hi_reg       <= '0;
      y_cur_reg      <= '0;
      y_hi_reg       <= '0;
      idx_reg        <= '0;
      base_reg       <= '0;
      gen_done_reg   <= 1'b0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      marks_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      x0_reg         <= x0_next;
      y0_reg         <= y0_next;
      x_cur_reg      <= x_cur_next;
      x_hi_reg       <= x_hi_next;
      y_cur_reg      <= y_cur_next;
      y_hi_reg       <= y_hi_next;
      idx_reg        <= idx_next;
      base_reg       <= base_next;
      gen_done_reg   <= gen_done_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      marks_reg      <= marks_next;
    end
  end

  assign event_ready = (state_reg == IDLE) && !reset;
  assign busy        = (state_reg != IDLE);
  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign marks_done  = marks_reg;
endmodule

// File: tb/tb_overlay_marker_writer.sv
// tb_overlay_marker_writer: directed marker events; expected writes queue up at stimulus
// time and are popped as the writer hands each word to the arbiter.
`timescale 1ns/1ps
module tb_overlay_marker_writer;
  localparam int          WIDTH  = 800;
  localparam int          HEIGHT = 600;
  localparam int          XW     = 10;
  localparam int          RADIUS = 2;
  localparam logic [31:0] DATA   = 32'hFFFFFFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          event_valid = 1'b0;
  logic          event_ready;
  logic [XW-1:0] event_x = '0;
  logic [XW-1:0] event_y = '0;
  logic [17:0]   base_addr = '0;
  logic [53:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          busy;
  logic [15:0]   marks_done;

  int          checks = 0;
  int          passed = 0;
  int          hs_count = 0;
  int          exp_marks = 0;
  logic [53:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [53:0] held_dout = '0;

  always #5 clock = ~clock;

  overlay_marker_writer dut (
    .clock      (clock),
    .reset      (reset),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_x    (event_x),
    .event_y    (event_y),
    .base_addr  (base_addr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .marks_done (marks_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [53:0] mk(input logic [3:0] m, input int addr);
    return {m, 18'(addr), DATA};
  endfunction

  // Reference: walk the clipped cross pixel by pixel and queue its writes
  function automatic int push_model(input int x, input int y, input logic [17:0] base);
    int xl, xh, yl, yh, k, idx, n;
    logic [3:0] m;
    n = 0;
    if (x >= WIDTH || y >= HEIGHT) return 0;
    xl = (x - RADIUS < 0) ? 0 : x - RADIUS;
    xh = (x + RADIUS > WIDTH - 1) ? WIDTH - 1 : x + RADIUS;
    yl = (y - RADIUS < 0) ? 0 : y - RADIUS;
    yh = (y + RADIUS > HEIGHT - 1) ? HEIGHT - 1 : y + RADIUS;
    k = xl;
    while (k <= xh) begin
      idx = y * WIDTH + k;
      m = 4'b0001 << (idx % 4);
`ifdef OVERLAY_COALESCE_EN
      while (k + 1 <= xh && (y * WIDTH + k + 1) / 4 == idx / 4) begin
        k++;
        m |= 4'b0001 << ((y * WIDTH + k) % 4);
      end
`endif
      exp_q.push_back({m, 18'(base + idx / 4), DATA});
      n++;
      k++;
    end
    for (int yy = yl; yy <= yh; yy++) begin
      if (yy != y) begin
        idx = yy * WIDTH + x;
        exp_q.push_back({4'b0001 << (idx % 4), 18'(base + idx / 4), DATA});
        n++;
      end
    end
    return n;
  endfunction

  // Hand-derived write list for event (10,5) with base 0
  function automatic int push_center_table();
`ifdef OVERLAY_COALESCE_EN
    exp_q.push_back(mk(4'b1111, 1002));
`else
    exp_q.push_back(mk(4'b0001, 1002));
    exp_q.push_back(mk(4'b0010, 1002));
    exp_q.push_back(mk(4'b0100, 1002));
    exp_q.push_back(mk(4'b1000, 1002));
`endif
    exp_q.push_back(mk(4'b0001, 1003));
    exp_q.push_back(mk(4'b0100, 602));
    exp_q.push_back(mk(4'b0100, 802));
    exp_q.push_back(mk(4'b0100, 1202));
    exp_q.push_back(mk(4'b0100, 1402));
`ifdef OVERLAY_COALESCE_EN
    return 6;
`else
    return 9;
`endif
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(dout_valid), 64'd1);
        check("hold_dout", 64'(dout), 64'(held_dout));
      end
      if (dout_valid && dout_ready) begin
        hs_count++;
        $display("write %0d: mask=%b addr=%0d data=%h", hs_count, dout[53:50], dout[49:32], dout[31:0]);
        if (exp_q.size() == 0) begin
          checks++;
          $error("FAIL unexpected_write observed=%h expected=none", dout);
        end else begin
          check("write_word", 64'(dout), 64'(exp_q.pop_front()));
        end
      end
      hold_pending = dout_valid && !dout_ready;
      held_dout = dout;
    end
  end

  task automatic send_event(input int x, input int y, input logic [17:0] base);
    check("accept_ready", 64'(event_ready), 64'd1);
    event_x = XW'(x);
    event_y = XW'(y);
    base_addr = base;
    event_valid = 1'b1;
    @(posedge clock); #1;
    event_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(event_ready), 64'd1);
    check({tag, "_marks"}, 64'(marks_done), 64'(exp_marks));
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_count < target && n < 200) begin
      @(posedge clock);
      n++;
    end
    check("hs_reached", 64'(hs_count >= target), 64'd1);
  endtask

  initial begin
    int h0, n;
    repeat (3) @(posedge clock);
    #1;
    check("rst_event_ready", 64'(event_ready), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_marks", 64'(marks_done), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(event_ready), 64'd1);

    // Centre event with latency check
    h0 = hs_count;
    n = push_center_table();
    send_event(10, 5, 18'd0);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_not_ready_busy", 64'(event_ready), 64'd0);
    check("s1_lat0", 64'(dout_valid), 64'd0);
    @(posedge clock); #1;
    check("s1_lat1", 64'(dout_valid), 64'd0);
    @(posedge clock); #1;
    check("s1_lat2", 64'(dout_valid), 64'd1);
    exp_marks++;
    wait_idle("s1");
    check("s1_count", 64'(hs_count - h0), 64'(n));

    // Same event, backpressure on the 4th write
    h0 = hs_count;
    n = push_center_table();
    send_event(10, 5, 18'd0);
    wait_hs(h0 + 3);
    #1;
    dout_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("s3_stall_valid", 64'(dout_valid), 64'd1);
    dout_ready = 1'b1;
    exp_marks++;
    wait_idle("s3");
    check("s3_count", 64'(hs_count - h0), 64'(n));

    // Top-left corner
    h0 = hs_count;
    n = push_model(0, 0, 18'd0);
    send_event(0, 0, 18'd0);
    exp_marks++;
    wait_idle("s2");
    check("s2_count", 64'(hs_count - h0), 64'(n));

    // Out-of-range event is swallowed, then bottom-right corner
    h0 = hs_count;
    send_event(800, 0, 18'd0);
    repeat (6) @(posedge clock);
    #1;
    check("s4_oor_idle", 64'(busy), 64'd0);
    check("s4_oor_writes", 64'(hs_count - h0), 64'd0);
    check("s4_oor_marks", 64'(marks_done), 64'(exp_marks));
    n = push_model(799, 599, 18'd0);
    send_event(799, 599, 18'd0);
    exp_marks++;
    wait_idle("s4");
    check("s4_count", 64'(hs_count - h0), 64'(n));

    // Address wrap past 2^18 words
    h0 = hs_count;
    n = push_model(3, 1, 18'h3FFF0);
    send_event(3, 1, 18'h3FFF0);
    exp_marks++;
    wait_idle("wrap");
    check("wrap_count", 64'(hs_count - h0), 64'(n));

    // Reset during the vertical arm
    h0 = hs_count;
    n = push_center_table();
    send_event(10, 5, 18'd0);
    wait_hs(h0 + n - 3);
    #1;
    reset = 1'b1;
    #1;
    check("s5_valid", 64'(dout_valid), 64'd0);
    check("s5_busy", 64'(busy), 64'd0);
    check("s5_ready_in_reset", 64'(event_ready), 64'd0);
    exp_q.delete();
    exp_marks = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("s5_ready", 64'(event_ready), 64'd1);
    check("s5_marks", 64'(marks_done), 64'd0);

    // Recovery after reset
    h0 = hs_count;
    n = push_model(0, 0, 18'd0);
    send_event(0, 0, 18'd0);
    exp_marks++;
    wait_idle("s5_after");
    check("s5_after_count", 64'(hs_count - h0), 64'(n));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
